// File: rtl/coin_payout_pkg.sv
// rtl/coin_payout_pkg.sv - shared state encoding and default timing constants for coin_payout
package coin_payout_pkg;

    localparam int GAP_CYCLES_DEF  = 2;
    localparam int ACK_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/payout_timer.sv
// rtl/payout_timer.sv - loadable down-counter with zero flag, shared by gap and ack-timeout timing
module payout_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/coin_payout.sv
// rtl/coin_payout.sv - coin hopper payout sequencer; ack timeout enabled by COIN_PAYOUT_TIMEOUT_EN
module coin_payout
    import coin_payout_pkg::*;
#(
    parameter int AMT_W       = 4,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             hopper_empty,
    input  logic             hopper_ack,
    output logic             coin_out,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] paid_count,
    output logic [AMT_W-1:0] shortfall
);

    // Timer is sized for the larger of both loads so the parameter set is identical in either build.
    localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
`ifdef COIN_PAYOUT_TIMEOUT_EN
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
`endif

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] paid_q, paid_d;
    logic [AMT_W-1:0] short_q, short_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;

    payout_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        paid_d      = paid_q;
        short_d     = short_q;
        tmr_load    = 1'b0;
        tmr_val     = GAP_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    remaining_d = req_amount;
                    paid_d      = '0;
                    short_d     = '0;
                    if (req_amount == '0) begin
                        state_d = ST_DONE;
                    end else if (hopper_empty) begin
                        state_d = ST_FAULT;
                        short_d = req_amount;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                state_d = ST_WAIT_ACK;
`ifdef COIN_PAYOUT_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = ACK_LOAD;
`endif
            end
            ST_WAIT_ACK: begin
                // An ack arriving in the expiry cycle is honoured before the timeout.
                if (hopper_ack) begin
                    paid_d      = paid_q + AMT_W'(1);
                    remaining_d = remaining_q - AMT_W'(1);
                    if (remaining_q == AMT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                    end
                end
`ifdef COIN_PAYOUT_TIMEOUT_EN
                else if (tmr_zero) begin
                    state_d = ST_FAULT;
                    short_d = remaining_q;
                end
`endif
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (hopper_empty) begin
                        state_d = ST_FAULT;
                        short_d = remaining_q;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            paid_q      <= '0;
            short_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
            short_q     <= short_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign coin_out   = (state_q == ST_PULSE);
    assign done       = (state_q == ST_DONE);
    assign fault      = (state_q == ST_FAULT);
    assign paid_count = paid_q;
    assign shortfall  = short_q;

endmodule
